hamming_tx: RTL
===============

# hamming_tx

Downstream stage of the 24-bit nibble buffer. It accepts 4-bit nibbles into a small FIFO and encodes each one as a Hamming(7,4) codeword. Each codeword is sent on a single-wire UART-style line: a start bit, the code bits MSB first, then a stop bit, at a fixed bit period. It isolates the one-nibble-per-cycle burst rate of the buffer from the much slower line rate.

## Interface
- CLKS_PER_BIT, 16: clk cycles per line bit; legal range ≥2.
- FIFO_DEPTH, 8: nibble FIFO entries; power of two, ≥6 (one full 24-bit word burst).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- nib_in  in  4  data nibble.
- nib_valid  in  1  nib_in valid this cycle.
- nib_ready  out  1  FIFO not full; a write occurs on nib_valid & nib_ready.
- tx_out  out  1  serial line; idles high.
- busy  out  1  high while a codeword is being sent (START through STOP).
- drop_cnt  out  8  saturating count of cycles with nib_valid & !nib_ready.

## Operation
- Encoding: d1=nib[3], d2=nib[2], d3=nib[1], d4=nib[0].
  - p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
  - Codeword bits 1..7 are p1 p2 d1 p3 d2 d3 d4 and are sent in that order.
- FIFO:
  - nib_ready = !full, driven from registered count.
  - A write while full is dropped, and drop_cnt increments and saturates at 255.
  - A simultaneous pop and write while full does not accept the write.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: tx_out=1. If the FIFO is non-empty, pop, latch the encoded codeword into the shift register, and go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: send the code bits MSB first, CLKS_PER_BIT cycles each. The bit counter runs 0..N-1; after the last bit, go to STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles. Then go to START if the FIFO is non-empty (popping and latching at that transition), otherwise go to IDLE.
  - There is no extra idle bit between back-to-back frames.
- busy=1 in START, DATA and STOP.
- Reset values: FIFO empty, nib_ready=1 on the first post-reset cycle, tx_out=1, busy=0, drop_cnt=0, FSM=IDLE.
- Writes presented while reset is high are ignored.
- Reset mid-frame aborts the frame immediately: tx_out is 1 in the cycle after the reset edge, and FIFO contents are discarded.

## Timing
- If nib_valid & nib_ready at edge N and the block is idle with an empty FIFO:
  - FIFO non-empty from N+1.
  - FSM pops at N+1.
  - tx_out falls at N+2.
- Frame length is (N+2)·CLKS_PER_BIT cycles, where N=7, or 8 with parity.
- tx_out, busy and drop_cnt are registered, with no combinational path from inputs.
- A burst of 6 nibbles on consecutive cycles into an empty FIFO is fully accepted with nib_ready held high.

## Configuration
- TX_PARITY_EN defined:
  - An 8th code bit is appended after d4, giving extended Hamming / SECDED.
  - The 8th bit is even parity over the 7 code bits, so the XOR of all 8 bits is 0.
  - The frame is 10 bits.
- TX_PARITY_EN undefined: 7 code bits and a 9-bit frame. The shift register and bit counter are sized accordingly.

## Structure
- Shared package comm_pkg holds:
  - constant CODE_W (7 or 8, following TX_PARITY_EN);
  - the hamming74 encode function;
  - the tx state enum (IDLE, START, DATA, STOP).
- Sub-module nibble_fifo(clk, reset, wr_en, wr_data, rd_en, rd_data, full, empty), parameterised by depth. It has a registered count and first-word-fall-through read data.
- hamming_tx contains the FSM, the bit-period counter, the bit counter, the shift register and drop_cnt.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Nibble 4'hB accepted once: codeword 0110011. tx_out carries 0, 0,1,1,0,0,1,1, 1 (start, code bits, stop), each held 4 cycles, with start low at acceptance+2. With TX_PARITY_EN the parity bit is 0 before stop.
- Nibble 4'hF gives 1111111; with TX_PARITY_EN the parity bit is 1. Nibble 4'h0 gives all-zero code bits.
- Six-nibble burst 1,2,3,4,5,6 on consecutive cycles: all accepted with nib_ready=1 throughout, then six back-to-back frames in order with busy continuously high and no idle gap.
- Holding nib_valid for 12 cycles with FIFO_DEPTH=8: nib_ready drops once full. drop_cnt equals the cycles with nib_valid & !nib_ready (3 or 4, depending on the pop during frame 1), and the frames sent match the accepted nibbles in order.
- Reset asserted mid-DATA: in the next cycle tx_out=1, busy=0, nib_ready=1, drop_cnt=0, and no further frames are sent.
- Sustained overflow for 300 cycles: drop_cnt saturates at 255 and does not wrap.

Source files
------------

// File: rtl/comm_pkg.sv
// Shared Hamming(7,4) transmit definitions: code width, encoder and FSM state type.
// TX_PARITY_EN appends an overall even-parity bit (extended Hamming / SECDED).
package comm_pkg;

`ifdef TX_PARITY_EN
    localparam int unsigned CODE_W = 8;
`else
    localparam int unsigned CODE_W = 7;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Returned MSB first in line order: p1 p2 d1 p3 d2 d3 d4 [p_all]
    function automatic logic [CODE_W-1:0] hamming74(input logic [3:0] nib);
        logic [6:0] c;
        c = {nib[3] ^ nib[2] ^ nib[0],
             nib[3] ^ nib[1] ^ nib[0],
             nib[3],
             nib[2] ^ nib[1] ^ nib[0],
             nib[2],
             nib[1],
             nib[0]};
`ifdef TX_PARITY_EN
        return {c, ^c};
`else
        return c;
`endif
    endfunction

endpackage

// File: rtl/nibble_fifo.sv
// Nibble FIFO with registered occupancy count and first-word-fall-through read data.
// DEPTH must be a power of two so the pointers wrap naturally.
module nibble_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_wr_en,
    input  logic [3:0] i_wr_data,
    input  logic       i_rd_en,
    output logic [3:0] o_rd_data,
    output logic       o_full,
    output logic       o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [3:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_do_wr   = i_wr_en & ~o_full;
    assign w_do_rd   = i_rd_en & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/hamming_tx.sv
// Buffers nibbles and sends each as a Hamming(7,4) codeword in a start/code/stop serial frame.
// Define TX_PARITY_EN for an 8-bit SECDED codeword and a 10-bit frame.
module hamming_tx
    import comm_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_nib_in,
    input  logic       i_nib_valid,
    output logic       o_nib_ready,
    output logic       o_tx_out,
    output logic       o_busy,
    output logic [7:0] o_drop_cnt
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(CODE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CODE_W - 1);

    tx_state_e         r_state;
    logic [CNT_W-1:0]  r_clk_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [CODE_W-1:0] r_shreg;
    logic              r_tx;
    logic              r_busy;
    logic [7:0]        r_drop_cnt;

    logic              w_full;
    logic              w_empty;
    logic [3:0]        w_rd_data;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_bit_done;
    logic              w_line;
    logic [CODE_W-1:0] w_code;

    assign w_wr_en    = i_nib_valid & ~w_full;
    assign w_bit_done = (r_clk_cnt == CNT_LAST);
    assign w_code     = hamming74(w_rd_data);
    // Pop only where the FSM latches a new codeword: from IDLE or at the end of STOP.
    assign w_rd_en    = ~w_empty & ((r_state == StIdle) | ((r_state == StStop) & w_bit_done));

    nibble_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (i_nib_in),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_comb begin
        w_line = 1'b1;
        case (r_state)
            StStart: w_line = 1'b0;
            StData:  w_line = r_shreg[CODE_W-1];
            default: w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_tx   <= w_line;
            r_busy <= (r_state != StIdle);
            if (i_nib_valid && w_full && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            case (r_state)
                StIdle: begin
                    r_clk_cnt <= '0;
                    if (!w_empty) begin
                        r_shreg <= w_code;
                        r_state <= StStart;
                    end
                end
                StStart: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= StData;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                StData: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        r_shreg   <= {r_shreg[CODE_W-2:0], 1'b0};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_state <= StStop;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        if (!w_empty) begin
                            r_shreg <= w_code;
                            r_state <= StStart;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_nib_ready = ~w_full;
    assign o_tx_out    = r_tx;
    assign o_busy      = r_busy;
    assign o_drop_cnt  = r_drop_cnt;

endmodule
